// File: rtl/cell_comm_fa_packet_tx.sv
// cell_comm_fa_packet_tx
//   Builds one fast-acquisition cell-comm packet per FA strobe and streams it into the TX
//   AXI-Stream of one Aurora cell-comm link. BPM X/Y positions and the cell index are snapshot
//   on an accepted strobe. The packet is: header {MAGIC, 6'b0, cellIndex}, sequence word, then
//   X[0], Y[0], X[1], Y[1], ... . All logic runs on the Aurora user clock.
//
// Parameters
//   BPM_COUNT  local BPMs per packet (1..8)
//   MAGIC      header tag placed in header word [31:16]
//   SEQ_INIT   sequence counter value after reset (normally 0)
//
// Ports
//   auroraUserClk     Aurora user clock
//   auroraUserResetN  asynchronous active-low reset
//   channelUp         Aurora channel up; loss while busy aborts the packet
//   faStrobe          single-cycle request for one packet
//   cellIndex         this cell's index, sampled on an accepted strobe
//   bpmData           {Y[n],X[n],...,Y[0],X[0]}, sampled on an accepted strobe
//   axisTxTvalid/Tlast/Tdata/Tready  AXI-Stream TX towards the Aurora core
//   busy              packet in progress
//   seqNumber         sequence counter value after the last fully sent packet
//   overrunCount      strobes dropped because busy (saturating)
//   dropCount         strobes dropped because the channel was down (saturating)
//   abortCount        packets aborted by channel loss (saturating)

module cell_comm_fa_packet_tx #(
    parameter int unsigned BPM_COUNT = 4,
    parameter logic [15:0] MAGIC     = 16'hA5BE,
    parameter logic [31:0] SEQ_INIT  = 32'h0000_0000
) (
    input  logic                   auroraUserClk,
    input  logic                   auroraUserResetN,
    input  logic                   channelUp,
    input  logic                   faStrobe,
    input  logic [9:0]             cellIndex,
    input  logic [BPM_COUNT*64-1:0] bpmData,
    output logic                   axisTxTvalid,
    output logic                   axisTxTlast,
    output logic [31:0]            axisTxTdata,
    input  logic                   axisTxTready,
    output logic                   busy,
    output logic [31:0]            seqNumber,
    output logic [15:0]            overrunCount,
    output logic [15:0]            dropCount,
    output logic [15:0]            abortCount
);

    localparam int unsigned NumData = 2 * BPM_COUNT;
    localparam int unsigned IdxW    = (NumData > 1) ? $clog2(NumData) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumData - 1);

    typedef enum logic [1:0] {StIdle, StHeader, StSeq, StData} stateT;

    stateT                     state;
    logic [IdxW-1:0]           wordIdx;
    logic [IdxW-1:0]           nextIdx;
    logic [31:0]               seqCounter;
    // Same bit layout as bpmData, so element k is data word k (X0, Y0, X1, ...).
    logic [NumData-1:0][31:0]  snapshot;

    function automatic logic [15:0] satInc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    assign nextIdx = wordIdx + IdxW'(1);
    assign busy    = (state != StIdle);

    always_ff @(posedge auroraUserClk or negedge auroraUserResetN) begin
        if (!auroraUserResetN) begin
            state        <= StIdle;
            wordIdx      <= '0;
            seqCounter   <= SEQ_INIT;
            snapshot     <= '0;
            axisTxTvalid <= 1'b0;
            axisTxTlast  <= 1'b0;
            axisTxTdata  <= 32'h0;
            seqNumber    <= 32'h0;
            overrunCount <= 16'h0;
            dropCount    <= 16'h0;
            abortCount   <= 16'h0;
        end else if (state == StIdle) begin
            if (faStrobe) begin
                if (channelUp) begin
                    snapshot     <= bpmData;
                    axisTxTdata  <= {MAGIC, 6'b0, cellIndex};
                    axisTxTvalid <= 1'b1;
                    axisTxTlast  <= 1'b0;
                    state        <= StHeader;
                end else begin
                    dropCount <= satInc(dropCount);
                end
            end
        end else begin
            if (faStrobe) begin
                overrunCount <= satInc(overrunCount);
            end
            // Channel loss wins over a handshake in the same cycle.
            if (!channelUp) begin
                state        <= StIdle;
                axisTxTvalid <= 1'b0;
                axisTxTlast  <= 1'b0;
                axisTxTdata  <= 32'h0;
                abortCount   <= satInc(abortCount);
            end else if (axisTxTready) begin
                case (state)
                    StHeader: begin
                        axisTxTdata <= seqCounter;
                        state       <= StSeq;
                    end
                    StSeq: begin
                        axisTxTdata <= snapshot[0];
                        axisTxTlast <= (LastIdx == '0);
                        wordIdx     <= '0;
                        state       <= StData;
                    end
                    StData: begin
                        if (wordIdx == LastIdx) begin
                            axisTxTvalid <= 1'b0;
                            axisTxTlast  <= 1'b0;
                            seqCounter   <= seqCounter + 32'd1;
                            seqNumber    <= seqCounter + 32'd1;
                            state        <= StIdle;
                        end else begin
                            wordIdx     <= nextIdx;
                            axisTxTdata <= snapshot[nextIdx];
                            axisTxTlast <= (nextIdx == LastIdx);
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cell_comm_fa_packet_tx.sv
// Bench for cell_comm_fa_packet_tx: a queue-based packet model checked every cycle against
// the main instance, plus literal expectations per scenario. A second instance with the
// sequence counter starting at 32'hFFFFFFFF covers wrap and asynchronous reset.

module tb_cell_comm_fa_packet_tx;

    localparam int unsigned Bpm      = 4;
    localparam int unsigned PktWords = 2 + 2 * Bpm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance signals
    logic              rstN = 1'b0;
    logic              channelUp = 1'b0;
    logic              faStrobe = 1'b0;
    logic [9:0]        cellIndex = '0;
    logic [Bpm*64-1:0] bpmData = '0;
    logic              tvalid, tlast;
    logic [31:0]       tdata;
    logic              tready = 1'b0;
    logic              busy;
    logic [31:0]       seqNumber;
    logic [15:0]       overrunCount, dropCount, abortCount;

    // Wrap/reset instance signals
    logic              rst2 = 1'b0;
    logic              ch2 = 1'b0;
    logic              strobe2 = 1'b0;
    logic [9:0]        cell2 = 10'h001;
    logic [Bpm*64-1:0] bpm2 = '0;
    logic              tvalid2, tlast2;
    logic [31:0]       tdata2;
    logic              ready2 = 1'b1;
    logic              busy2;
    logic [31:0]       seqNumber2;
    logic [15:0]       overrun2, drop2, abort2;

    cell_comm_fa_packet_tx #(.BPM_COUNT(Bpm)) dut (
        .auroraUserClk(clk), .auroraUserResetN(rstN), .channelUp(channelUp),
        .faStrobe(faStrobe), .cellIndex(cellIndex), .bpmData(bpmData),
        .axisTxTvalid(tvalid), .axisTxTlast(tlast), .axisTxTdata(tdata),
        .axisTxTready(tready), .busy(busy), .seqNumber(seqNumber),
        .overrunCount(overrunCount), .dropCount(dropCount), .abortCount(abortCount)
    );

    cell_comm_fa_packet_tx #(.BPM_COUNT(Bpm), .SEQ_INIT(32'hFFFF_FFFF)) dut2 (
        .auroraUserClk(clk), .auroraUserResetN(rst2), .channelUp(ch2),
        .faStrobe(strobe2), .cellIndex(cell2), .bpmData(bpm2),
        .axisTxTvalid(tvalid2), .axisTxTlast(tlast2), .axisTxTdata(tdata2),
        .axisTxTready(ready2), .busy(busy2), .seqNumber(seqNumber2),
        .overrunCount(overrun2), .dropCount(drop2), .abortCount(abort2)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit checkEn = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] sat(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // ---------------- Behavioural model of the main instance ----------------
    // mQ holds the words still to be delivered; its head is what must be on the bus.
    logic [31:0] mQ[$];
    logic [15:0] mOver, mDrop, mAbort;
    logic [31:0] mSeq, mSeqNum;

    always @(posedge clk) begin
        if (!rstN) begin
            mQ.delete();
            mOver = 0; mDrop = 0; mAbort = 0; mSeq = 0; mSeqNum = 0;
        end else if (mQ.size() != 0) begin
            if (faStrobe) mOver = sat(mOver);
            if (!channelUp) begin
                mAbort = sat(mAbort);
                mQ.delete();
            end else if (tready) begin
                void'(mQ.pop_front());
                if (mQ.size() == 0) begin
                    mSeq    = mSeq + 32'd1;
                    mSeqNum = mSeq;
                end
            end
        end else if (faStrobe) begin
            if (channelUp) begin
                mQ.push_back({16'hA5BE, 6'b0, cellIndex});
                mQ.push_back(mSeq);
                for (int k = 0; k < 2 * Bpm; k++) mQ.push_back(bpmData[k*32 +: 32]);
            end else begin
                mDrop = sat(mDrop);
            end
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            check("tvalid", {31'b0, tvalid}, {31'b0, mQ.size() != 0});
            check("busy", {31'b0, busy}, {31'b0, mQ.size() != 0});
            if (mQ.size() != 0) begin
                check("tdata", tdata, mQ[0]);
                check("tlast", {31'b0, tlast}, {31'b0, mQ.size() == 1});
            end
            check("overrunCount", {16'b0, overrunCount}, {16'b0, mOver});
            check("dropCount", {16'b0, dropCount}, {16'b0, mDrop});
            check("abortCount", {16'b0, abortCount}, {16'b0, mAbort});
            check("seqNumber", seqNumber, mSeqNum);
        end
    end

    // ---------------- Handshake monitors ----------------
    logic [31:0] gotW[$];
    bit          gotL[$];
    int          gotC[$];
    logic [31:0] got2[$];

    always @(negedge clk) begin
        if (rstN && tvalid && tready) begin
            gotW.push_back(tdata);
            gotL.push_back(tlast);
            gotC.push_back(cyc);
        end
        if (rst2 && tvalid2 && ready2) got2.push_back(tdata2);
    end

    function automatic int countLast();
        int n = 0;
        foreach (gotL[i]) n += int'(gotL[i]);
        return n;
    endfunction

    // ---------------- Stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe1();
        faStrobe = 1'b1;
        step(1);
        faStrobe = 1'b0;
    endtask

    task automatic clearGot();
        gotW.delete();
        gotL.delete();
        gotC.delete();
    endtask

    // Waits until the model has no packet in flight; optionally toggles tready each cycle.
    task automatic waitIdle(input string name, input bit toggle);
        int i = 0;
        while (mQ.size() != 0 && i < 100) begin
            if (toggle) tready = ~tready;
            step(1);
            i++;
        end
        tready = 1'b1;
        if (mQ.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s: packet still in flight after %0d cycles, want idle", name, i);
        end
        step(1);
    endtask

    task automatic waitIdle2(input string name);
        int i = 0;
        while (busy2 && i < 100) begin
            step(1);
            i++;
        end
        total++;
        if (busy2) begin
            bad++;
            $display("FAIL %s: busy=%0d after %0d cycles, want 0", name, busy2, i);
        end
        step(1);
    endtask

    task automatic checkPacket(input string name, input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2, input logic [31:0] w9);
        check({name, "_words"}, gotW.size(), PktWords);
        check({name, "_tlastCount"}, countLast(), 1);
        if (gotW.size() == PktWords) begin
            check({name, "_w0"}, gotW[0], w0);
            check({name, "_w1"}, gotW[1], w1);
            check({name, "_w2"}, gotW[2], w2);
            check({name, "_w9"}, gotW[9], w9);
            check({name, "_lastOnW9"}, {31'b0, gotL[9]}, 32'd1);
        end
    endtask

    initial begin
        int strobeCyc;
        int i;

        step(3);
        check("rst_tvalid", {31'b0, tvalid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_seqNumber", seqNumber, 32'd0);
        check("rst_dropCount", {16'b0, dropCount}, 32'd0);
        rstN = 1'b1;
        rst2 = 1'b1;
        checkEn = 1'b1;
        channelUp = 1'b1;
        tready = 1'b1;
        step(2);

        // 1: basic packet, tready held high
        cellIndex = 10'h155;
        for (int k = 0; k < 2 * Bpm; k++) bpmData[k*32 +: 32] = 32'h11 * (k + 1);
        clearGot();
        strobeCyc = cyc;
        strobe1();
        waitIdle("t1", 1'b0);
        checkPacket("t1", 32'hA5BE0155, 32'h0, 32'h11, 32'h88);
        if (gotC.size() == PktWords) check("t1_lastLatency", gotC[9] - strobeCyc, 10);
        check("t1_seqNumber", seqNumber, 32'd1);

        // 2: tready toggling every cycle
        clearGot();
        strobe1();
        waitIdle("t2", 1'b1);
        checkPacket("t2", 32'hA5BE0155, 32'h1, 32'h11, 32'h88);
        check("t2_seqNumber", seqNumber, 32'd2);

        // 3: second strobe three cycles after the first is an overrun
        cellIndex = 10'h3FF;
        for (int k = 0; k < 2 * Bpm; k++) bpmData[k*32 +: 32] = 32'hDEAD0000 + k;
        clearGot();
        strobe1();
        step(2);
        strobe1();
        waitIdle("t3", 1'b0);
        checkPacket("t3", 32'hA5BE03FF, 32'h2, 32'hDEAD0000, 32'hDEAD0007);
        check("t3_overrun", {16'b0, overrunCount}, 32'd1);
        check("t3_seqNumber", seqNumber, 32'd3);

        // 4: strobes while the channel is down are dropped
        clearGot();
        channelUp = 1'b0;
        repeat (5) begin
            strobe1();
            step(1);
        end
        check("t4_dropCount", {16'b0, dropCount}, 32'd5);
        check("t4_noWords", gotW.size(), 0);
        channelUp = 1'b1;
        step(1);
        strobe1();
        waitIdle("t4", 1'b0);
        checkPacket("t4", 32'hA5BE03FF, 32'h3, 32'hDEAD0000, 32'hDEAD0007);
        check("t4_seqNumber", seqNumber, 32'd4);

        // 5: channel loss after the fourth accepted word aborts the packet
        clearGot();
        strobe1();
        i = 0;
        while (gotW.size() < 4 && i < 20) begin
            step(1);
            i++;
        end
        check("t5_fourWords", gotW.size(), 4);
        tready = 1'b0;
        channelUp = 1'b0;
        step(1);
        check("t5_tvalidLow", {31'b0, tvalid}, 32'd0);
        check("t5_abortCount", {16'b0, abortCount}, 32'd1);
        check("t5_seqNumber", seqNumber, 32'd4);
        step(1);
        channelUp = 1'b1;
        tready = 1'b1;
        step(1);
        clearGot();
        strobe1();
        waitIdle("t5b", 1'b0);
        checkPacket("t5b", 32'hA5BE03FF, 32'h4, 32'hDEAD0000, 32'hDEAD0007);
        check("t5_seqAfter", seqNumber, 32'd5);

        // 6: sequence wrap and asynchronous reset on the second instance
        for (int k = 0; k < 2 * Bpm; k++) bpm2[k*32 +: 32] = 32'hC0DE0000 + k;
        ch2 = 1'b1;
        step(1);
        got2.delete();
        strobe2 = 1'b1;
        step(1);
        strobe2 = 1'b0;
        waitIdle2("t6a");
        check("t6_words1", got2.size(), PktWords);
        if (got2.size() == PktWords) check("t6_w1_first", got2[1], 32'hFFFFFFFF);
        check("t6_seqWrap", seqNumber2, 32'd0);
        got2.delete();
        strobe2 = 1'b1;
        step(1);
        strobe2 = 1'b0;
        step(2);
        strobe2 = 1'b1;
        step(1);
        strobe2 = 1'b0;
        waitIdle2("t6b");
        check("t6_words2", got2.size(), PktWords);
        if (got2.size() == PktWords) check("t6_w1_second", got2[1], 32'h0);
        check("t6_seqAfterWrap", seqNumber2, 32'd1);
        check("t6_overrun", {16'b0, overrun2}, 32'd1);
        strobe2 = 1'b1;
        step(1);
        strobe2 = 1'b0;
        step(3);
        check("t6_midPacketValid", {31'b0, tvalid2}, 32'd1);
        #2;
        rst2 = 1'b0;
        #1;
        check("t6_rstTvalid", {31'b0, tvalid2}, 32'd0);
        check("t6_rstBusy", {31'b0, busy2}, 32'd0);
        check("t6_rstSeqNumber", seqNumber2, 32'd0);
        check("t6_rstOverrun", {16'b0, overrun2}, 32'd0);
        step(2);

        // 7: drop counter saturates rather than wrapping
        channelUp = 1'b0;
        faStrobe = 1'b1;
        step(65535);
        faStrobe = 1'b0;
        step(1);
        check("t7_dropSat", {16'b0, dropCount}, 32'h0000FFFF);
        channelUp = 1'b1;
        step(2);

        checkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
